iter_mul_unit: RTL

ITER_MUL_UNIT -- requirements
Module: iter_mul_unit

---
 rtl/mul_pkg.sv | 24 ++
 rtl/iter_mul_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M multiply unit: FSM states,
// funct3 encodings of the multiply ops and the shift-add iteration count.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam int MUL_ITER = 32;
  localparam int CNT_W    = $clog2(MUL_ITER);

  // Two's-complement magnitude; 0x80000000 maps to 2^31 as an unsigned value.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/iter_mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Works on operand magnitudes and fixes the sign once at the end.
module iter_mul_unit
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        kill,
  output logic        mul_stall,
  output logic        mul_done,
  output logic [31:0] mul_result
);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fin_q, fin_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [31:0]      result_q, result_d;
  logic [2:0]       f3_q, f3_d;
  logic             sign_q, sign_d;

  logic             a_signed, b_signed;
  logic             neg_a, neg_b;
  logic             start_ok;
  logic [63:0]      prod;

  assign a_signed = (funct3E != F3_MULHU);
  assign b_signed = (funct3E == F3_MUL) || (funct3E == F3_MULH);
  assign neg_a    = a_signed & op_a[31];
  assign neg_b    = b_signed & op_b[31];
  assign start_ok = startE & ~funct3E[2] & ~kill;
  assign prod     = sign_q ? (~acc_q + 64'd1) : acc_q;

  // fin_q marks that all 32 steps are accumulated; the following BUSY cycle
  // applies the sign and registers the selected half.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fin_d     = fin_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    result_d  = result_q;
    f3_d      = f3_q;
    sign_d    = sign_q;
    mul_stall = 1'b0;
    mul_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          mul_stall = 1'b1;
          state_d   = BUSY;
          f3_d      = funct3E;
          sign_d    = neg_a ^ neg_b;
          mcand_d   = {32'd0, mag32(op_a, neg_a)};
          mplier_d  = mag32(op_b, neg_b);
          acc_d     = 64'd0;
          cnt_d     = CNT_W'(MUL_ITER - 1);
          fin_d     = 1'b0;
        end
      end

      BUSY: begin
        mul_stall = 1'b1;
        if (kill) begin
          state_d = IDLE;
          fin_d   = 1'b0;
        end else if (fin_q) begin
          state_d  = DONE;
          fin_d    = 1'b0;
          result_d = (f3_q == F3_MUL) ? prod[31:0] : prod[63:32];
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = {mcand_q[62:0], 1'b0};
          mplier_d = {1'b0, mplier_q[31:1]};
          if (cnt_q == '0) begin
            fin_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      DONE: begin
        mul_done = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      result_q <= 32'd0;
      f3_q     <= 3'd0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      f3_q     <= f3_d;
      sign_q   <= sign_d;
    end
  end

  assign mul_result = result_q;

endmodule
